// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and types for the 1-to-8 TDM demultiplexer
// Purpose: lane count, slot index width, FSM state enum and slot index type.
// Ports: none (package).
package tdm_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic [SEL_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(N_LANES - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - wrapping slot counter with sync load-to-1 and terminal count
// Purpose: tracks the lane index the next accepted beat is written to.
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset, clears slot to 0
//   en_i     in   advance by one, wrapping 7->0
//   load1_i  in   sync beat taken as lane 0, so the next lane is 1 (wins over en_i)
//   slot_o   out  current slot index
//   tc_o     out  high while slot is the last lane
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  en_i,
  input  logic  load1_i,
  output slot_t slot_o,
  output logic  tc_o
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load1_i) begin
      slot_d = slot_t'(1);
    end else if (en_i) begin
      // Natural SEL_W-bit overflow provides the 7->0 wrap.
      slot_d = slot_q + slot_t'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;
  assign tc_o   = (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_1_8.sv
// rtl/tdm_demux_1_8.sv - frame-synchronised 1-to-8 serial-to-parallel TDM demultiplexer
// Purpose: steers serial lane bits into a shadow register and publishes each
// complete frame as a registered word with a one-cycle valid pulse.
// Ports:
//   clk_i         in   clock
//   rst_i         in   asynchronous active-high reset
//   din_i         in   serial bit for the current slot
//   din_valid_i   in   beat qualifier
//   frame_sync_i  in   marks a valid beat as lane 0
//   q_o           out  last complete frame, bit i = lane i
//   q_valid_o     out  one-cycle pulse when q_o updates
//   slot_o        out  lane index for the next valid beat
//   locked_o      out  frame alignment acquired
//   sync_err_o    out  one-cycle pulse on a misaligned frame_sync
module tdm_demux_1_8
  import tdm_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               din_i,
  input  logic               din_valid_i,
  input  logic               frame_sync_i,
  output logic [N_LANES-1:0] q_o,
  output logic               q_valid_o,
  output slot_t              slot_o,
  output logic               locked_o,
  output logic               sync_err_o
);

  state_e             state_q;
  logic [N_LANES-1:0] shadow_q;
  logic [N_LANES-1:0] q_q;
  logic               q_valid_q;
  logic               sync_err_q;
  logic               locked_q;

  slot_t              slot;
  logic               tc;
  logic               is_locked;
  logic               sync_beat;
  logic               accept;
  logic               misalign;
  logic               complete;
  slot_t              wr_idx;
  logic [N_LANES-1:0] lane_we;

  assign is_locked = (state_q == LOCKED);
  assign sync_beat = din_valid_i & frame_sync_i;
  // In HUNT only a sync beat is taken; in LOCKED every valid beat is.
  assign accept    = din_valid_i & (frame_sync_i | is_locked);
  assign misalign  = sync_beat & is_locked & (slot != '0);
  // A sync at slot 7 is misaligned, so it never completes a frame.
  assign complete  = accept & tc & ~misalign;

  tdm_slot_ctr u_slot_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (din_valid_i & is_locked),
    .load1_i (sync_beat),
    .slot_o  (slot),
    .tc_o    (tc)
  );

  // Any sync beat lands in lane 0 regardless of where the counter was.
  assign wr_idx = frame_sync_i ? slot_t'(0) : slot;

  always_comb begin
    lane_we = '0;
    if (accept) begin
      lane_we[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      shadow_q   <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      q_valid_q  <= 1'b0;
      sync_err_q <= 1'b0;
      shadow_q   <= (shadow_q & ~lane_we) | ({N_LANES{din_i}} & lane_we);
      case (state_q)
        HUNT: begin
          if (sync_beat) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (misalign) begin
            sync_err_q <= 1'b1;
          end else if (complete) begin
            // Lane 7 comes straight from din; lanes 0..6 are already in shadow.
            q_q       <= {din_i, shadow_q[N_LANES-2:0]};
            q_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign q_o        = q_q;
  assign q_valid_o  = q_valid_q;
  assign slot_o     = slot;
  assign locked_o   = locked_q;
  assign sync_err_o = sync_err_q;

endmodule
